// File: rtl/chain_decode_if.sv
// Handshake/result bundle for chain_decode.
//   in_valid/in_ready/syndrome_in         : syndrome input handshake
//   out_valid/out_ready                   : result output handshake
//   correction_out/residual_out/rounds_out/converged_out : decode result
// master = syndrome producer / result consumer, slave = the decoder.
interface chain_decode_if #(
  parameter int NUM_ANC = 8,
  parameter int RW      = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [NUM_ANC-1:0] syndrome_in;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_ANC:0]   correction_out;
  logic [NUM_ANC-1:0] residual_out;
  logic [RW-1:0]      rounds_out;
  logic               converged_out;

  modport master (
    output in_valid, syndrome_in, out_ready,
    input  in_ready, out_valid, correction_out, residual_out, rounds_out, converged_out
  );

  modport slave (
    input  in_valid, syndrome_in, out_ready,
    output in_ready, out_valid, correction_out, residual_out, rounds_out, converged_out
  );
endinterface

// File: rtl/chain_decode.sv
// Greedy nearest-neighbour decoder for a 1-D repetition-code chain.
// Ancilla i sits between data i and data i+1. Rounds alternate EVEN pairs
// (2k,2k+1) and ODD pairs (2k+1,2k+2); a pair with both bits set flips the
// data qubit between them and clears both ancillas. Decoding stops when the
// residual is empty, MAX_ROUNDS rounds have run, or two rounds in a row
// found nothing.
// Ports: clk, rst (async, active-high), bus (chain_decode_if.slave):
//   syndrome in handshake, correction/residual/rounds/converged out handshake.
// Optional macro CHAIN_DECODE_BOUNDARY_EN: a set end ancilla that is unpaired
// in the current phase is matched to the chain boundary.
module chain_decode #(
  parameter int NUM_ANC    = 8,
  parameter int MAX_ROUNDS = 4,
  parameter int RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  chain_decode_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} state_t;

  state_t             state, next_state;
  logic [NUM_ANC-1:0] res, res_n;
  logic [NUM_ANC:0]   corr, corr_n;
  logic [RW-1:0]      rounds, rounds_inc;
  logic               prev_match;
  logic               any_match;
  logic               ready_q;
  logic               accept;
  logic               stop;
  logic               odd;

  // in_ready is registered from next_state so that it rises on the first
  // edge after reset and on the edge that completes the output handshake.
  assign accept     = bus.in_valid && ready_q;
  assign odd        = (state == ODD);
  assign rounds_inc = rounds + RW'(1);

  // One matching round over the current residual.
  always_comb begin
    res_n     = res;
    corr_n    = corr;
    any_match = 1'b0;
    for (int unsigned i = 0; i + 1 < NUM_ANC; i++) begin
      if (((i % 2) == 1) == odd && res[i] && res[i+1]) begin
        res_n[i]    = 1'b0;
        res_n[i+1]  = 1'b0;
        corr_n[i+1] = ~corr_n[i+1];
        any_match   = 1'b1;
      end
    end
`ifdef CHAIN_DECODE_BOUNDARY_EN
    // Ancilla 0 is unpaired in ODD; the last ancilla is unpaired in the
    // phase whose parity matches its index.
    if (odd && res[0]) begin
      res_n[0]  = 1'b0;
      corr_n[0] = ~corr_n[0];
      any_match = 1'b1;
    end
    if ((((NUM_ANC - 1) % 2) == 1) == odd && res[NUM_ANC-1]) begin
      res_n[NUM_ANC-1] = 1'b0;
      corr_n[NUM_ANC]  = ~corr_n[NUM_ANC];
      any_match        = 1'b1;
    end
`endif
  end

  // prev_match starts at 1 so a single empty first round does not stall.
  assign stop = (res_n == '0) || (rounds_inc == RW'(MAX_ROUNDS)) ||
                (!any_match && !prev_match);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = (bus.syndrome_in == '0) ? DONE : EVEN;
      EVEN:     next_state = stop ? DONE : ODD;
      ODD:      next_state = stop ? DONE : EVEN;
      DONE:     if (bus.out_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res        <= '0;
      corr       <= '0;
      rounds     <= '0;
      prev_match <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            res        <= bus.syndrome_in;
            corr       <= '0;
            rounds     <= '0;
            prev_match <= 1'b1;
          end
        end
        EVEN, ODD: begin
          res        <= res_n;
          corr       <= corr_n;
          rounds     <= rounds_inc;
          prev_match <= any_match;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = ready_q;
  assign bus.out_valid      = (state == DONE);
  assign bus.correction_out = corr;
  assign bus.residual_out   = res;
  assign bus.rounds_out     = rounds;
  assign bus.converged_out  = (res == '0);

endmodule

// File: doc/chain_decode.md
CHAIN_DECODE -- requirements
Module: chain_decode

Interface
REQ-001 Parameter NUM_ANC, default 8, number of ancilla (syndrome) bits on a 1-D repetition chain; legal range 2 or more.
REQ-002 Parameter MAX_ROUNDS, default 4, maximum number of matching rounds per syndrome; legal range 2 or more.
REQ-003 Parameter RW, default $clog2(MAX_ROUNDS+1), width of the round counter.
REQ-004 clk  input  1  single clock for the block, all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  syndrome_in is valid.
REQ-007 in_ready  output  1  block accepts a syndrome; high only in IDLE.
REQ-008 syndrome_in  input  NUM_ANC  ancilla measurement bits; ancilla i sits between data i and data i+1.
REQ-009 out_valid  output  1  result is valid; high only in DONE.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 correction_out  output  NUM_ANC+1  data-qubit flip mask.
REQ-012 residual_out  output  NUM_ANC  ancillas left unmatched.
REQ-013 rounds_out  output  RW  matching rounds executed.
REQ-014 converged_out  output  1  high when residual_out is zero.

Function
REQ-015 The FSM SHALL have four states: IDLE, EVEN, ODD and DONE.
REQ-016 On in_valid&in_ready the block SHALL latch syndrome_in into the residual register, clear the correction and round registers, and go to EVEN; a zero syndrome SHALL go straight to DONE with rounds 0.
REQ-017 An EVEN round SHALL evaluate pairs (2k,2k+1); an ODD round SHALL evaluate pairs (2k+1,2k+2); pairs are evaluated in parallel within one cycle.
REQ-018 A pair (i,i+1) with both bits set SHALL match: it toggles correction bit i+1 and clears residual bits i and i+1.
REQ-019 Each round SHALL take exactly one clock, increment the round counter, and alternate EVEN and ODD.
REQ-020 After a round, the FSM SHALL go to DONE if the residual is zero, if the round count equals MAX_ROUNDS, or if this round and the previous round both produced no match; otherwise it SHALL go to the opposite phase.
REQ-021 In DONE, outputs SHALL hold stable while out_ready is low; on out_valid&out_ready the FSM SHALL return to IDLE.
REQ-022 in_ready and out_valid SHALL never be high in the same cycle; a new syndrome is accepted no earlier than the cycle after the output handshake.
REQ-023 Latency SHALL be 1 + (number of rounds) clocks from the input handshake edge to out_valid; a zero syndrome gives 1 clock.
REQ-024 converged_out SHALL equal (residual_out == 0) at all times.

Reset
REQ-025 While rst is high, the block SHALL force state to IDLE and clear correction_out, residual_out, rounds_out and out_valid; converged_out SHALL read 1 and in_ready SHALL read 0.
REQ-026 After rst falls, in_ready SHALL go high from the first clock edge. A reset asserted mid-round SHALL abandon the syndrome with no output handshake.

Configuration
REQ-027 Macro CHAIN_DECODE_BOUNDARY_EN: when defined, a set ancilla at a chain end that is unpaired in the current phase SHALL match to the boundary.
REQ-028 Boundary matching is defined as follows. Ancilla 0 in ODD toggles correction bit 0. Ancilla NUM_ANC-1, in whichever phase leaves it unpaired, toggles correction bit NUM_ANC. In both cases the ancilla is cleared and the round counts as a match.
REQ-029 When CHAIN_DECODE_BOUNDARY_EN is undefined, unpaired end ancillas SHALL be left untouched. Port list and timing SHALL be identical in both builds.

Verification (NUM_ANC=8, MAX_ROUNDS=4)
REQ-030 syndrome 8'h03 -> EVEN match; one clock after the round, out_valid=1, correction 9'h002, residual 8'h00, rounds 1, converged 1.
REQ-031 syndrome 8'h06 -> EVEN no match, ODD match; correction 9'h004, residual 0, rounds 2, converged 1.
REQ-032 syndrome 8'h01 -> without the macro: stall after 2 rounds, correction 9'h000, residual 8'h01, converged 0. With the macro: correction 9'h001, residual 0, rounds 2.
REQ-033 syndrome 8'h00 -> out_valid one clock after accept, rounds 0, correction 0, converged 1.
REQ-034 syndrome 8'h03 with out_ready held low 5 cycles -> outputs stable and in_ready low throughout; IDLE reached one clock after out_ready rises.
REQ-035 syndrome 8'h06 with rst pulsed during the first round -> all outputs equal the reset values immediately; a following syndrome decodes normally.
